// File: rtl/stopwatch_ctrl_if.sv
// Purpose: button, counter-status and control/display signals between the board-side logic and stopwatch_ctrl.
// Latency: none; the interface is wiring only.
// Backpressure: none; every signal is a level or a single-cycle pulse with no handshake.
interface stopwatch_ctrl_if;
  logic       btn_start;
  logic       btn_lap;
  logic       btn_dir;
  logic       cnt_zero;
  logic       go;
  logic       up;
  logic       clr;
  logic       lap_load;
  logic       lap_hold;
  logic       alarm;
  logic       blink;
  logic [1:0] state;

  // Board / datapath side: drives the raw buttons and the counter status.
  modport master (
    output btn_start, btn_lap, btn_dir, cnt_zero,
    input  go, up, clr, lap_load, lap_hold, alarm, blink, state
  );

  // Controller side.
  modport slave (
    input  btn_start, btn_lap, btn_dir, cnt_zero,
    output go, up, clr, lap_load, lap_hold, alarm, blink, state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Purpose: stopwatch control FSM with synchronised, debounced buttons; optional blink via STOPWATCH_BLINK_EN.
// Latency: raw press to registered outputs is DB_CYCLES+4 clk edges; the FSM itself reacts one edge after a press pulse.
// Backpressure: none; presses that lose same-cycle priority or arrive in a state that ignores them are dropped.
module stopwatch_ctrl #(
  parameter int DB_CYCLES    = 20000,
`ifdef STOPWATCH_BLINK_EN
  parameter int BLINK_CYCLES = 25000000,
`endif
  parameter int ALARM_CYCLES = 50000000
) (
  input  logic             clk,
  input  logic             rstn,
  stopwatch_ctrl_if.slave  bus
);

  localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int ALW = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
  localparam logic [ALW-1:0] AL_LAST = ALW'(ALARM_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_ALARM = 2'b11
  } state_t;

  // Button bit order everywhere: [0] start, [1] lap, [2] dir.
  logic [2:0]     w_btn_raw;
  logic [2:0]     r_sync1;
  logic [2:0]     r_sync2;
  logic [2:0]     r_acc;
  logic [2:0]     r_acc_d;
  logic [2:0]     r_arm;
  logic [2:0]     r_press;
  logic [DBW-1:0] r_db_cnt [3];

  assign w_btn_raw = {bus.btn_dir, bus.btn_lap, bus.btn_start};

  // Synchronise, debounce and edge-detect each button.
  // A button is only armed once it has been seen stably released, so a
  // button held through reset debounces to 1 silently and must be
  // released and pressed again before it produces a press pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_acc   <= '0;
      r_acc_d <= '0;
      r_arm   <= '0;
      r_press <= '0;
      for (int i = 0; i < 3; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
      r_acc_d <= r_acc;
      r_press <= r_acc & ~r_acc_d & r_arm;
      for (int i = 0; i < 3; i++) begin
        if (r_sync1[i] != r_sync2[i]) begin
          // Synchronised level is about to change: restart the stability window.
          r_db_cnt[i] <= '0;
        end else if ((r_sync2[i] != r_acc[i]) || (!r_arm[i] && !r_sync2[i])) begin
          if (r_db_cnt[i] == DB_LAST) begin
            r_db_cnt[i] <= '0;
            if (r_sync2[i] != r_acc[i]) begin
              r_acc[i] <= r_sync2[i];
            end else begin
              r_arm[i] <= 1'b1;
            end
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + DBW'(1);
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  logic           w_start;
  logic           w_lap;
  logic           w_dir;
  logic           w_cz_down;
  logic           w_alarm_done;
  state_t         w_state_nxt;
  state_t         r_state;
  logic           r_go;
  logic           r_up;
  logic           r_clr;
  logic           r_lap_load;
  logic           r_lap_hold;
  logic           r_alarm;
  logic [ALW-1:0] r_alarm_cnt;

  assign w_start      = r_press[0];
  assign w_lap        = r_press[1];
  assign w_dir        = r_press[2];
  assign w_cz_down    = ~r_up & bus.cnt_zero;
  assign w_alarm_done = (r_alarm_cnt == AL_LAST);

  // Next-state decode; start outranks lap, and countdown expiry outranks everything in RUN.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start && !w_cz_down) w_state_nxt = S_RUN;
      S_RUN:   begin
                 if (w_cz_down)    w_state_nxt = S_ALARM;
                 else if (w_start) w_state_nxt = S_PAUSE;
               end
      S_PAUSE: begin
                 if (w_start)    w_state_nxt = S_RUN;
                 else if (w_lap) w_state_nxt = S_IDLE;
               end
      S_ALARM: if (w_start || w_lap || w_alarm_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state and all registered control outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_go        <= 1'b0;
      r_up        <= 1'b1;
      r_clr       <= 1'b0;
      r_lap_load  <= 1'b0;
      r_lap_hold  <= 1'b0;
      r_alarm     <= 1'b0;
      r_alarm_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_go       <= (w_state_nxt == S_RUN);
      r_alarm    <= (w_state_nxt == S_ALARM);
      r_clr      <= 1'b0;
      r_lap_load <= 1'b0;
      // Alarm timer runs only while staying in ALARM, so it is zero on entry.
      if ((r_state == S_ALARM) && (w_state_nxt == S_ALARM)) begin
        r_alarm_cnt <= r_alarm_cnt + ALW'(1);
      end else begin
        r_alarm_cnt <= '0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            // Either starts the run or is ignored; lap/dir in this cycle are dropped.
          end else if (w_lap) begin
            r_clr      <= 1'b1;
            r_lap_hold <= 1'b0;
          end else if (w_dir) begin
            r_up <= ~r_up;
          end
        end
        S_RUN: begin
          if (!w_cz_down && !w_start && w_lap) begin
            if (r_lap_hold) begin
              r_lap_hold <= 1'b0;
            end else begin
              r_lap_load <= 1'b1;
              r_lap_hold <= 1'b1;
            end
          end
        end
        S_PAUSE: begin
          if (!w_start && w_lap) begin
            r_clr      <= 1'b1;
            r_lap_hold <= 1'b0;
          end
        end
        S_ALARM: begin
          if (w_state_nxt == S_IDLE) begin
            r_clr      <= 1'b1;
            r_lap_hold <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.state    = r_state;
  assign bus.go       = r_go;
  assign bus.up       = r_up;
  assign bus.clr      = r_clr;
  assign bus.lap_load = r_lap_load;
  assign bus.lap_hold = r_lap_hold;
  assign bus.alarm    = r_alarm;

`ifdef STOPWATCH_BLINK_EN
  localparam int BLW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BLW-1:0] BL_LAST = BLW'(BLINK_CYCLES - 1);

  logic           r_blink;
  logic [BLW-1:0] r_blink_cnt;

  // Blink toggles in PAUSE/ALARM; any state change restarts the period and IDLE/RUN show steadily.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_blink     <= 1'b1;
      r_blink_cnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_blink_cnt <= '0;
      if ((w_state_nxt == S_IDLE) || (w_state_nxt == S_RUN)) begin
        r_blink <= 1'b1;
      end
    end else if ((r_state == S_PAUSE) || (r_state == S_ALARM)) begin
      if (r_blink_cnt == BL_LAST) begin
        r_blink_cnt <= '0;
        r_blink     <= ~r_blink;
      end else begin
        r_blink_cnt <= r_blink_cnt + BLW'(1);
      end
    end
  end

  assign bus.blink = r_blink;
`else
  assign bus.blink = 1'b1;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Purpose: scoreboard bench for stopwatch_ctrl; expected output changes are queued by the stimulus and popped by a monitor.
// Latency: expected timings assume press-to-output of DB+4 edges and one edge from cnt_zero to ALARM.
// Backpressure: not applicable; every observed output change must match the head of the queue.
module tb_stopwatch_ctrl;

  localparam int DB = 4;
  localparam int AL = 16;
`ifdef STOPWATCH_BLINK_EN
  localparam int BL = 8;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  int   cyc  = 0;
  int   total = 0;
  int   bad   = 0;

  stopwatch_ctrl_if sw ();

`ifdef STOPWATCH_BLINK_EN
  stopwatch_ctrl #(.DB_CYCLES(DB), .BLINK_CYCLES(BL), .ALARM_CYCLES(AL)) dut (
    .clk(clk), .rstn(rstn), .bus(sw)
  );
`else
  stopwatch_ctrl #(.DB_CYCLES(DB), .ALARM_CYCLES(AL)) dut (
    .clk(clk), .rstn(rstn), .bus(sw)
  );
`endif

  typedef struct packed {
    logic [1:0] st;
    logic       go;
    logic       up;
    logic       clr;
    logic       ll;
    logic       lh;
    logic       al;
  } obs_t;

  obs_t exp_q [$];
  int   cyc_q [$];
  obs_t cur;
  obs_t prev = 'x;
  obs_t m_exp;
  int   m_cyc;

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic obs_t mk(input int st, input int go, input int up, input int clr,
                              input int ll, input int lh, input int al);
    obs_t r;
    r.st  = st[1:0];
    r.go  = go[0];
    r.up  = up[0];
    r.clr = clr[0];
    r.ll  = ll[0];
    r.lh  = lh[0];
    r.al  = al[0];
    return r;
  endfunction

  task automatic expect_obs(input obs_t v, input int c);
    exp_q.push_back(v);
    cyc_q.push_back(c);
  endtask

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // m = {dir, lap, start}; hold long enough to debounce, then release and let it settle.
  task automatic press(input logic [2:0] m);
    sw.btn_start = m[0];
    sw.btn_lap   = m[1];
    sw.btn_dir   = m[2];
    tick(10);
    sw.btn_start = 1'b0;
    sw.btn_lap   = 1'b0;
    sw.btn_dir   = 1'b0;
    tick(14);
  endtask

  // Monitor: every change of the observable outputs must match the next queued expectation.
  always @(negedge clk) begin
    cur = {sw.state, sw.go, sw.up, sw.clr, sw.lap_load, sw.lap_hold, sw.alarm};
    if (cur !== prev) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_change cyc=%0d got=%b", cyc, cur);
      end else begin
        m_exp = exp_q.pop_front();
        m_cyc = cyc_q.pop_front();
        if (cur !== m_exp) begin
          bad++;
          $display("FAIL obs_value cyc=%0d got=%b exp=%b", cyc, cur, m_exp);
        end else if ((m_cyc >= 0) && (m_cyc != cyc)) begin
          bad++;
          $display("FAIL obs_timing value=%b got_cyc=%0d exp_cyc=%0d", cur, cyc, m_cyc);
        end
      end
      prev = cur;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    int p;
    int expb;
    sw.btn_start = 1'b0;
    sw.btn_lap   = 1'b0;
    sw.btn_dir   = 1'b0;
    sw.cnt_zero  = 1'b0;
    expect_obs(mk(0, 0, 1, 0, 0, 0, 0), -1);
    #1 rstn = 1'b0;
    tick(3);
    rstn = 1'b1;

    // Quiet idle after reset.
    tick(100);
    chk("idle_state", int'(sw.state), 0);
    chk("idle_blink", int'(sw.blink), 1);

    // Short glitch is filtered, a real press starts the run with fixed latency.
    sw.btn_start = 1'b1;
    tick(3);
    sw.btn_start = 1'b0;
    tick(20);
    chk("glitch_state", int'(sw.state), 0);
    expect_obs(mk(1, 1, 1, 0, 0, 0, 0), cyc + DB + 4);
    press(3'b001);
    chk("run_go", int'(sw.go), 1);

    // Lap hold on, lap hold off, pause, clear.
    expect_obs(mk(1, 1, 1, 0, 1, 1, 0), cyc + DB + 4);
    expect_obs(mk(1, 1, 1, 0, 0, 1, 0), cyc + DB + 5);
    press(3'b010);
    chk("lap_hold_on", int'(sw.lap_hold), 1);
    expect_obs(mk(1, 1, 1, 0, 0, 0, 0), cyc + DB + 4);
    press(3'b010);
    p = cyc + DB + 4;
    expect_obs(mk(2, 0, 1, 0, 0, 0, 0), p);
    press(3'b001);
    for (int i = 0; i < 16; i++) begin
`ifdef STOPWATCH_BLINK_EN
      expb = ((((cyc - p) / BL) % 2) == 0) ? 1 : 0;
`else
      expb = 1;
`endif
      chk("pause_blink", int'(sw.blink), expb);
      tick(1);
    end
    expect_obs(mk(0, 0, 1, 1, 0, 0, 0), cyc + DB + 4);
    expect_obs(mk(0, 0, 1, 0, 0, 0, 0), cyc + DB + 5);
    press(3'b010);

    // Direction toggle, blocked countdown start, countdown expiry and alarm timeout.
    expect_obs(mk(0, 0, 0, 0, 0, 0, 0), cyc + DB + 4);
    press(3'b100);
    sw.cnt_zero = 1'b1;
    press(3'b001);
    chk("cz_start_ignored", int'(sw.state), 0);
    sw.cnt_zero = 1'b0;
    expect_obs(mk(1, 1, 0, 0, 0, 0, 0), cyc + DB + 4);
    press(3'b001);
    expect_obs(mk(3, 0, 0, 0, 0, 0, 1), cyc + 1);
    expect_obs(mk(0, 0, 0, 1, 0, 0, 0), cyc + 1 + AL);
    expect_obs(mk(0, 0, 0, 0, 0, 0, 0), cyc + 2 + AL);
    sw.cnt_zero = 1'b1;
    tick(AL + 10);
    chk("alarm_cleared", int'(sw.alarm), 0);
    sw.cnt_zero = 1'b0;

    // Dir ignored in RUN; start beats lap in the same cycle.
    expect_obs(mk(1, 1, 0, 0, 0, 0, 0), cyc + DB + 4);
    press(3'b001);
    press(3'b100);
    expect_obs(mk(2, 0, 0, 0, 0, 0, 0), cyc + DB + 4);
    press(3'b011);
    chk("combo_lap_hold", int'(sw.lap_hold), 0);
    expect_obs(mk(1, 1, 0, 0, 0, 0, 0), cyc + DB + 4);
    press(3'b001);

    // Asynchronous reset mid-run with start held.
    sw.btn_start = 1'b1;
    tick(3);
    expect_obs(mk(0, 0, 1, 0, 0, 0, 0), -1);
    #2 rstn = 1'b0;
    #1;
    chk("async_go", int'(sw.go), 0);
    chk("async_state", int'(sw.state), 0);
    tick(2);
    rstn = 1'b1;
    tick(30);
    chk("held_no_press", int'(sw.state), 0);
    sw.btn_start = 1'b0;
    tick(20);
    expect_obs(mk(1, 1, 1, 0, 0, 0, 0), cyc + DB + 4);
    press(3'b001);
    tick(5);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drained got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
